// File: rtl/regfile_fib_checker_pkg.sv
// Shared definitions for the register-file Fibonacci checker.
// Holds the sweep FSM state encoding and the default bus widths.
// Imported by the checker top and its history-window sub-module.
package regfile_fib_checker_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/regfile_fib_checker_fib_window.sv
// Two-deep history of accepted values plus a saturating beat counter.
// Latency: mismatch is combinational from din and the stored history.
// Backpressure: history only advances when shift is asserted (a handshake).
module regfile_fib_checker_fib_window
  import regfile_fib_checker_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              shift,
  input  logic [DATA_W-1:0] din,
  output logic              mismatch
);

  logic [DATA_W-1:0] prev1_q, prev1_d;
  logic [DATA_W-1:0] prev2_q, prev2_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W:0]   sum_full;
  logic [DATA_W-1:0] sum_w;
  logic              sum_carry_unused;

  // Sum is formed one bit wider; the carry is discarded so wrap-around is legal.
  assign sum_full = {1'b0, prev1_q} + {1'b0, prev2_q};
  assign {sum_carry_unused, sum_w} = sum_full;

  // The first two beats only seed the history, so they never flag.
  assign mismatch = (cnt_q == 2'd2) && (din != sum_w);

  // Next-state for the history: clear on a new sweep, shift on each accepted beat.
  always_comb begin
    prev1_d = prev1_q;
    prev2_d = prev2_q;
    cnt_d   = cnt_q;
    if (clr) begin
      prev1_d = '0;
      prev2_d = '0;
      cnt_d   = 2'd0;
    end else if (shift) begin
      prev2_d = prev1_q;
      prev1_d = din;
      cnt_d   = (cnt_q == 2'd2) ? 2'd2 : cnt_q + 2'd1;
    end
  end

  // History registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev1_q <= '0;
      prev2_q <= '0;
      cnt_q   <= 2'd0;
    end else begin
      prev1_q <= prev1_d;
      prev2_q <= prev2_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/regfile_fib_checker.sv
// Sweeps FIRST_REG..LAST_REG, streams each value and checks the Fibonacci property.
// Latency: 2 cycles per register (READ then EMIT); first valid 1 cycle after Start is sampled.
// Backpressure: DataValid/DataOut held in EMIT until DataReady; no beat dropped or repeated.
module regfile_fib_checker
  import regfile_fib_checker_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 15
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  output logic [ADDR_W-1:0] RdAddr,
  input  logic [DATA_W-1:0] RdData,
  output logic [DATA_W-1:0] DataOut,
  output logic              DataValid,
  input  logic              DataReady,
  output logic              Busy,
  output logic              Done,
  output logic              Pass,
  output logic [ADDR_W-1:0] ErrIdx
);

  localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_REG);
  localparam logic [ADDR_W-1:0] ADDR_1  = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              data_vld_q, data_vld_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] err_idx_q, err_idx_d;
  logic              win_clr, win_shift, win_mismatch;

  regfile_fib_checker_fib_window #(
    .DATA_W (DATA_W)
  ) u_fib_window (
    .clk      (Clk),
    .rst_n    (Rst),
    .clr      (win_clr),
    .shift    (win_shift),
    .din      (data_out_q),
    .mismatch (win_mismatch)
  );

  // Sweep FSM next-state and output computation; Start is honoured only in IDLE/DONE.
  always_comb begin
    state_d    = state_q;
    rd_addr_d  = rd_addr_q;
    data_out_d = data_out_q;
    data_vld_d = data_vld_q;
    done_d     = done_q;
    pass_d     = pass_q;
    err_d      = err_q;
    err_idx_d  = err_idx_q;
    win_clr    = 1'b0;
    win_shift  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          state_d   = ST_READ;
          rd_addr_d = FIRST_A;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          err_d     = 1'b0;
          err_idx_d = '0;
          win_clr   = 1'b1;
        end
      end
      ST_READ: begin
        data_out_d = RdData;
        data_vld_d = 1'b1;
        state_d    = ST_EMIT;
      end
      ST_EMIT: begin
        if (DataReady) begin
          win_shift = 1'b1;
          if (win_mismatch && !err_q) begin
            err_d     = 1'b1;
            err_idx_d = rd_addr_q;
          end
          data_vld_d = 1'b0;
          if (rd_addr_q == LAST_A) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            pass_d  = ~err_d;
          end else begin
            rd_addr_d = rd_addr_q + ADDR_1;
            state_d   = ST_READ;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_READ) || (state_d == ST_EMIT);
  end

  // State and registered outputs; reset returns everything to idle at once.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q    <= ST_IDLE;
      rd_addr_q  <= FIRST_A;
      data_out_q <= '0;
      data_vld_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= 1'b0;
      err_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      data_out_q <= data_out_d;
      data_vld_q <= data_vld_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      err_idx_q  <= err_idx_d;
    end
  end

  assign RdAddr    = rd_addr_q;
  assign DataOut   = data_out_q;
  assign DataValid = data_vld_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Pass      = pass_q;
  assign ErrIdx    = err_idx_q;

endmodule

// File: tb/tb_regfile_fib_checker.sv
// Self-checking bench for regfile_fib_checker with a register-file model and beat scoreboard.
// Expected beats are queued from the model at sweep start and popped on each handshake.
// Each scenario task checks its own end-of-sweep status inline.
module tb_regfile_fib_checker;

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
  } beat_t;

  logic        Clk;
  logic        Rst;
  logic        Start;
  logic [3:0]  RdAddr;
  logic [15:0] RdData;
  logic [15:0] DataOut;
  logic        DataValid;
  logic        DataReady;
  logic        Busy;
  logic        Done;
  logic        Pass;
  logic [3:0]  ErrIdx;

  logic [15:0] regs [16];
  beat_t       exp_q [$];
  int          checks = 0;
  int          errors = 0;

  assign RdData = regs[RdAddr];

  regfile_fib_checker dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Start     (Start),
    .RdAddr    (RdAddr),
    .RdData    (RdData),
    .DataOut   (DataOut),
    .DataValid (DataValid),
    .DataReady (DataReady),
    .Busy      (Busy),
    .Done      (Done),
    .Pass      (Pass),
    .ErrIdx    (ErrIdx)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic load_fib();
    regs[0] = 16'd0;
    regs[1] = 16'd1;
    for (int k = 2; k < 16; k++) regs[k] = regs[k-1] + regs[k-2];
  endtask

  // Builds a fully consistent sequence backwards from r15=1, r14=0xFFFF (r13 becomes 2).
  task automatic load_wrap();
    regs[15] = 16'h0001;
    regs[14] = 16'hFFFF;
    for (int k = 15; k >= 2; k--) regs[k-2] = regs[k] - regs[k-1];
  endtask

  // Drives one sweep and scoreboards every handshake; returns early with Rst low at reset_beat.
  task automatic run_sweep(input int stall_beat, input int stall_n, input bit start_in_stall,
                           input int reset_beat, output int done_edges, output int beats,
                           output int first_vld);
    beat_t b;
    int    edges;
    int    stalled;
    exp_q.delete();
    for (int a = 0; a < 16; a++) begin
      b.addr = 4'(a);
      b.data = regs[a];
      exp_q.push_back(b);
    end
    beats = 0; done_edges = -1; first_vld = -1; stalled = 0;
    @(posedge Clk); #1 Start = 1'b1; DataReady = 1'b1;
    @(posedge Clk); #1 Start = 1'b0; edges = 1;
    checks++;
    if (Done !== 1'b0 || Pass !== 1'b0 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL start_clears: Done=%b Pass=%b Busy=%b, need 0 0 1", Done, Pass, Busy);
    end
    while (edges < 200) begin
      @(negedge Clk);
      if (Done === 1'b1) begin
        done_edges = edges;
        break;
      end
      if (DataValid === 1'b1) begin
        if (first_vld < 0) first_vld = edges;
        if (beats == reset_beat) begin
          Rst = 1'b0;
          return;
        end
        if (beats == stall_beat && stalled < stall_n) begin
          DataReady = 1'b0;
          Start = start_in_stall;
          stalled++;
          checks++;
          if (DataOut !== exp_q[0].data) begin
            errors++;
            $display("FAIL stall_hold: DataOut=%h, need %h", DataOut, exp_q[0].data);
          end
        end else begin
          DataReady = 1'b1;
          Start = 1'b0;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL extra_beat: addr=%0d data=%h beyond 16", RdAddr, DataOut);
          end else begin
            b = exp_q.pop_front();
            if (DataOut !== b.data || RdAddr !== b.addr || Busy !== 1'b1) begin
              errors++;
              $display("FAIL beat%0d: addr=%0d data=%h busy=%b, need addr=%0d data=%h busy=1",
                       beats, RdAddr, DataOut, Busy, b.addr, b.data);
            end
          end
          beats++;
        end
      end
      @(posedge Clk); #1 edges++;
    end
    Start = 1'b0;
    DataReady = 1'b1;
    if (done_edges < 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: no Done within %0d edges", edges);
    end
  endtask

  task automatic test_reset();
    Rst = 1'b0; Start = 1'b0; DataReady = 1'b1;
    load_fib();
    #12;
    checks++;
    if (RdAddr !== 4'd0 || DataOut !== 16'd0 || DataValid !== 1'b0 || Busy !== 1'b0 ||
        Done !== 1'b0 || Pass !== 1'b0 || ErrIdx !== 4'd0) begin
      errors++;
      $display("FAIL reset: addr=%0d out=%h vld=%b busy=%b done=%b pass=%b idx=%0d, need all 0",
               RdAddr, DataOut, DataValid, Busy, Done, Pass, ErrIdx);
    end
    @(negedge Clk); Rst = 1'b1;
  endtask

  task automatic test_basic();
    int de, nb, fv;
    load_fib();
    run_sweep(-1, 0, 1'b0, -1, de, nb, fv);
    checks++;
    if (nb != 16 || exp_q.size() != 0) begin
      errors++; $display("FAIL basic_beats: got %0d beats, need 16", nb);
    end
    checks++;
    if (fv != 2) begin errors++; $display("FAIL basic_first_valid: edge %0d, need 2", fv); end
    checks++;
    if (de != 33) begin errors++; $display("FAIL basic_done_latency: edge %0d, need 33", de); end
    checks++;
    if (Done !== 1'b1 || Pass !== 1'b1 || Busy !== 1'b0 || DataValid !== 1'b0) begin
      errors++;
      $display("FAIL basic_status: done=%b pass=%b busy=%b vld=%b, need 1 1 0 0",
               Done, Pass, Busy, DataValid);
    end
  endtask

  task automatic test_single_error();
    int de, nb, fv;
    load_fib();
    regs[9] = 16'd35;
    run_sweep(-1, 0, 1'b0, -1, de, nb, fv);
    checks++;
    if (nb != 16) begin errors++; $display("FAIL err1_beats: got %0d, need 16", nb); end
    checks++;
    if (Done !== 1'b1 || Pass !== 1'b0 || ErrIdx !== 4'd9) begin
      errors++;
      $display("FAIL err1_status: done=%b pass=%b idx=%0d, need 1 0 9", Done, Pass, ErrIdx);
    end
  endtask

  task automatic test_rerun_from_done();
    int de, nb, fv;
    load_fib();
    run_sweep(-1, 0, 1'b0, -1, de, nb, fv);
    checks++;
    if (de != 33 || Done !== 1'b1 || Pass !== 1'b1 || ErrIdx !== 4'd0) begin
      errors++;
      $display("FAIL rerun_status: edge=%0d done=%b pass=%b idx=%0d, need 33 1 1 0",
               de, Done, Pass, ErrIdx);
    end
  endtask

  task automatic test_two_errors();
    int de, nb, fv;
    load_fib();
    regs[5]  = 16'd6;
    regs[12] = 16'd0;
    run_sweep(-1, 0, 1'b0, -1, de, nb, fv);
    checks++;
    if (Done !== 1'b1 || Pass !== 1'b0 || ErrIdx !== 4'd5) begin
      errors++;
      $display("FAIL err2_status: done=%b pass=%b idx=%0d, need 1 0 5", Done, Pass, ErrIdx);
    end
  endtask

  task automatic test_stall_and_start_ignored();
    int de, nb, fv;
    load_fib();
    run_sweep(4, 3, 1'b1, -1, de, nb, fv);
    checks++;
    if (nb != 16 || exp_q.size() != 0) begin
      errors++; $display("FAIL stall_beats: got %0d beats, need 16", nb);
    end
    checks++;
    if (de != 36) begin errors++; $display("FAIL stall_done_latency: edge %0d, need 36", de); end
    checks++;
    if (Done !== 1'b1 || Pass !== 1'b1) begin
      errors++; $display("FAIL stall_status: done=%b pass=%b, need 1 1", Done, Pass);
    end
  endtask

  task automatic test_wrap();
    int de, nb, fv;
    load_wrap();
    run_sweep(-1, 0, 1'b0, -1, de, nb, fv);
    checks++;
    if (regs[13] !== 16'h0002 || Done !== 1'b1 || Pass !== 1'b1 || nb != 16) begin
      errors++;
      $display("FAIL wrap_status: done=%b pass=%b idx=%0d beats=%0d, need 1 1 - 16",
               Done, Pass, ErrIdx, nb);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int de, nb, fv;
    load_fib();
    regs[5] = 16'd6;
    run_sweep(-1, 0, 1'b0, 7, de, nb, fv);
    #1;
    checks++;
    if (RdAddr !== 4'd0 || DataOut !== 16'd0 || DataValid !== 1'b0 || Busy !== 1'b0 ||
        Done !== 1'b0 || Pass !== 1'b0 || ErrIdx !== 4'd0) begin
      errors++;
      $display("FAIL midreset: addr=%0d out=%h vld=%b busy=%b done=%b pass=%b idx=%0d, need 0s",
               RdAddr, DataOut, DataValid, Busy, Done, Pass, ErrIdx);
    end
    @(posedge Clk); #1;
    checks++;
    if (Done !== 1'b0 || DataValid !== 1'b0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_hold: done=%b vld=%b busy=%b, need 0 0 0", Done, DataValid, Busy);
    end
    @(negedge Clk); Rst = 1'b1;
    load_fib();
    run_sweep(-1, 0, 1'b0, -1, de, nb, fv);
    checks++;
    if (de != 33 || nb != 16 || Done !== 1'b1 || Pass !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_sweep: edge=%0d beats=%0d done=%b pass=%b, need 33 16 1 1",
               de, nb, Done, Pass);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single_error();
    test_rerun_from_done();
    test_two_errors();
    test_stall_and_start_ignored();
    test_wrap();
    test_reset_mid_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
